// File: rtl/wptr_full_ctrl_pkg.sv
// Shared pointer parameters for the async FIFO write and read controllers.
package wptr_full_ctrl_pkg;

  localparam int WPTR_N        = 9;
  localparam int WPTR_DEPTH    = 2 ** (WPTR_N - 1);
  localparam int WPTR_AF_LEVEL = WPTR_DEPTH - 4;

endpackage

// File: rtl/wptr_full_ctrl_b2g.sv
// Binary to Gray converter.
module b2g #(
  parameter int N = 9
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/wptr_full_ctrl.sv
// Write-side pointer / full-flag controller for the async FIFO (write clock domain).
// Optional almost-full flag is built when WPTR_ALMOST_FULL_EN is defined.
module wptr_full_ctrl
  import wptr_full_ctrl_pkg::*;
#(
  parameter int N        = WPTR_N,
  parameter int AF_LEVEL = 2 ** (N - 1) - 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [N-1:0] rd_gray,
  output logic [N-2:0] waddr,
  output logic         wr_ok,
  output logic [N-1:0] wptr_gray,
  output logic         full,
  output logic         almost_full
);

  localparam logic [N-1:0] AF_LVL = N'(AF_LEVEL);

  logic [N-1:0] wbin;
  logic [N-1:0] wgray;
  logic [N-1:0] rq1;
  logic [N-1:0] rq2;
  logic         full_r;
  logic [N-1:0] wbin_next;
  logic [N-1:0] wgray_next;
  logic [N-1:0] full_gray;

  assign wr_ok     = wr_en & ~full_r;
  assign wbin_next = wbin + {{(N-1){1'b0}}, wr_ok};

  b2g #(.N(N)) u_b2g (
    .bin  (wbin_next),
    .gray (wgray_next)
  );

  // Write pointer is full when it sits one lap ahead of the synchronized read pointer.
  assign full_gray = {~rq2[N-1], ~rq2[N-2], rq2[N-3:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin   <= '0;
      wgray  <= '0;
      rq1    <= '0;
      rq2    <= '0;
      full_r <= 1'b0;
    end else begin
      rq1    <= rd_gray;
      rq2    <= rq1;
      wbin   <= wbin_next;
      wgray  <= wgray_next;
      full_r <= (wgray_next == full_gray);
    end
  end

  assign waddr     = wbin[N-2:0];
  assign wptr_gray = wgray;
  assign full      = full_r;

`ifdef WPTR_ALMOST_FULL_EN
  logic [N-1:0] rbin_sync;
  logic [N-1:0] fill_next;
  logic         af_r;

  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i < N; i++) begin
      rbin_sync[i] = ^rq2[N-1:i];
    end
  end

  assign fill_next = wbin_next - rbin_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      af_r <= 1'b0;
    end else begin
      af_r <= (fill_next >= AF_LVL);
    end
  end

  assign almost_full = af_r;
`else
  logic unused_af;
  assign unused_af   = ^AF_LVL;
  assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Self-checking bench for wptr_full_ctrl; honours WPTR_ALMOST_FULL_EN when defined.
module tb_wptr_full_ctrl;

  localparam int N = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_en;
  logic [N-1:0] rd_gray;
  logic [N-2:0] waddr;
  logic         wr_ok;
  logic [N-1:0] wptr_gray;
  logic         full;
  logic         almost_full;

  wptr_full_ctrl #(.N(N), .AF_LEVEL(252)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_gray     (rd_gray),
    .waddr       (waddr),
    .wr_ok       (wr_ok),
    .wptr_gray   (wptr_gray),
    .full        (full),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

`ifdef WPTR_ALMOST_FULL_EN
  localparam bit AF_ON = 1'b1;
`else
  localparam bit AF_ON = 1'b0;
`endif

  typedef struct {
    logic [N-2:0] waddr;
    logic [N-1:0] gray;
    logic         full;
    logic         af;
  } exp_t;

  typedef struct {
    logic         we;
    logic [N-1:0] rg;
    logic [N-2:0] waddr;
    logic [N-1:0] gray;
    logic         full;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: binary write pointer and the two synchronizer stages.
  logic [N-1:0] mwbin;
  logic [N-1:0] mrq1;
  logic [N-1:0] mrq2;
  logic         mfull;

  function automatic logic [N-1:0] tb_b2g(input logic [N-1:0] b);
    logic [N-1:0] g;
    for (int i = 0; i < N - 1; i++) g[i] = b[i] ^ b[i+1];
    g[N-1] = b[N-1];
    return g;
  endfunction

  function automatic logic [N-1:0] tb_g2b(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mwbin = '0;
    mrq1  = '0;
    mrq2  = '0;
    mfull = 1'b0;
    sb.delete();
  endtask

  // Called at posedge+1: drive, predict, clock, then compare against the scoreboard.
  task automatic step(input logic we, input logic [N-1:0] rg);
    logic         ok;
    logic [N-1:0] nb;
    logic [N-1:0] fill;
    exp_t         e;
    exp_t         got;
    wr_en   = we;
    rd_gray = rg;
    ok      = we & ~mfull;
    #1;
    chk("wr_ok", int'(wr_ok), int'(ok));
    nb       = mwbin + N'(ok);
    fill     = nb - tb_g2b(mrq2);
    e.waddr  = nb[N-2:0];
    e.gray   = tb_b2g(nb);
    e.full   = (fill == 9'd256);
    e.af     = AF_ON && (fill >= 9'd252);
    sb.push_back(e);
    mfull = e.full;
    mwbin = nb;
    mrq2  = mrq1;
    mrq1  = rg;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("waddr", int'(waddr), int'(got.waddr));
    chk("wptr_gray", int'(wptr_gray), int'(got.gray));
    chk("full", int'(full), int'(got.full));
    chk("almost_full", int'(almost_full), int'(got.af));
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    wr_en   = 1'b0;
    rd_gray = '0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t         vecs[8];
  logic [N-1:0] prev_gray;
  logic         saw_wrap;
  int           hd;

  initial begin
    vecs[0] = '{1'b1, 9'h000, 8'd1, 9'h001, 1'b0};
    vecs[1] = '{1'b1, 9'h000, 8'd2, 9'h003, 1'b0};
    vecs[2] = '{1'b0, 9'h000, 8'd2, 9'h003, 1'b0};
    vecs[3] = '{1'b1, 9'h000, 8'd3, 9'h002, 1'b0};
    vecs[4] = '{1'b1, 9'h000, 8'd4, 9'h006, 1'b0};
    vecs[5] = '{1'b0, 9'h001, 8'd4, 9'h006, 1'b0};
    vecs[6] = '{1'b1, 9'h001, 8'd5, 9'h007, 1'b0};
    vecs[7] = '{1'b1, 9'h001, 8'd6, 9'h005, 1'b0};

    // Reset state, checked before any clock edge reaches the design.
    rst     = 1'b1;
    wr_en   = 1'b1;
    rd_gray = 9'h0AA;
    #1;
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_gray", int'(wptr_gray), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_wr_ok_follows", int'(wr_ok), 1);
    do_reset();

    // Table vectors with hand-computed expectations.
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].we, vecs[i].rg);
      chk($sformatf("vec%0d_waddr", i), int'(waddr), int'(vecs[i].waddr));
      chk($sformatf("vec%0d_gray", i), int'(wptr_gray), int'(vecs[i].gray));
      chk($sformatf("vec%0d_full", i), int'(full), int'(vecs[i].full));
    end

    // Fill to full with the reader idle.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      chk("fill_waddr_pre", int'(waddr), i % 256);
      chk("fill_full_pre", int'(full), 0);
      step(1'b1, 9'h000);
    end
    chk("full_gray", int'(wptr_gray), 9'h180);
    chk("full_flag", int'(full), 1);
    chk("full_wr_ok", int'(wr_ok), 0);

    // Pushes against a full FIFO are dropped.
    for (int i = 0; i < 10; i++) step(1'b1, 9'h000);
    chk("hold_waddr", int'(waddr), 0);
    chk("hold_gray", int'(wptr_gray), 9'h180);

    // One read frees a slot; full drops on the third edge.
    step(1'b0, 9'h001);
    chk("rd_full_e1", int'(full), 1);
    step(1'b0, 9'h001);
    chk("rd_full_e2", int'(full), 1);
    step(1'b0, 9'h001);
    chk("rd_full_e3", int'(full), 0);
    wr_en = 1'b1;
    #1;
    chk("rd_next_waddr", int'(waddr), 0);
    chk("rd_next_wr_ok", int'(wr_ok), 1);
    step(1'b1, 9'h001);
    chk("rd_push_full", int'(full), 1);

    // Long run with the reader keeping up: pointer wraps, Gray steps by one bit.
    do_reset();
    saw_wrap = 1'b0;
    for (int i = 0; i < 600; i++) begin
      prev_gray = wptr_gray;
      step(1'b1, tb_b2g(mwbin));
      hd = $countones(prev_gray ^ wptr_gray);
      chk("wrap_hamming", hd, 1);
      if (prev_gray == 9'h100 && wptr_gray == 9'h000) saw_wrap = 1'b1;
    end
    chk("wrap_seen", int'(saw_wrap), 1);

    // Reset asserted mid-cycle during a burst clears everything before the next edge.
    do_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 9'h000);
    wr_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_waddr", int'(waddr), 0);
    chk("mid_rst_gray", int'(wptr_gray), 0);
    chk("mid_rst_full", int'(full), 0);
    chk("mid_rst_af", int'(almost_full), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_waddr", int'(waddr), 0);
    step(1'b1, 9'h000);
    chk("post_rst_push", int'(waddr), 1);
    for (int i = 0; i < 29; i++) step(1'b1, 9'h000);

    // Almost-full threshold and its release after a read of four entries.
    do_reset();
    for (int i = 0; i < 251; i++) step(1'b1, 9'h000);
    chk("af_251", int'(almost_full), 0);
    step(1'b1, 9'h000);
    chk("af_252", int'(almost_full), int'(AF_ON));
    step(1'b0, 9'h006);
    step(1'b0, 9'h006);
    chk("af_rd_e2", int'(almost_full), int'(AF_ON));
    step(1'b0, 9'h006);
    chk("af_rd_e3", int'(almost_full), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
